// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL lock detector.
// Holds the detector FSM encoding and the synchroniser depth.
package adpll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_HOLD   = 2'd3
   } ld_state_e;

   localparam int LD_SYNC_STAGES = 2;

   // Feedback-edge counter per period: 0, 1, or "2 or more".
   function automatic logic [1:0] fbn_inc(input logic [1:0] n);
      logic [1:0] r;
      if (n == 2'd2) begin
         r = 2'd2;
      end else begin
         r = n + 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adpll_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Used for both the reference and the feedback clock.
module adpll_edge_sync
   import adpll_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [LD_SYNC_STAGES-1:0] sync_r;
   logic                      last_r;
   logic                      rise_r;

   // Synchronise din and register a one-cycle pulse on its rising edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_r <= '0;
         last_r <= 1'b0;
         rise_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[LD_SYNC_STAGES-2:0], din};
         last_r <= sync_r[LD_SYNC_STAGES-1];
         rise_r <= sync_r[LD_SYNC_STAGES-1] & ~last_r;
      end
   end

   assign rise = rise_r;

endmodule

// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: per-reference-period phase error and lock qualification.
// Optional feature macro ADPLL_LD_SLIP_CNT_EN enables the cycle-slip counter.
module adpll_lock_detect
   import adpll_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clk_ref,
   input  logic             fb_clk,
   input  logic [CNT_W-1:0] tol,
   output logic             lock,
   output logic             lock_lost,
   output logic [CNT_W-1:0] phase_err,
   output logic             phase_valid,
   output logic [1:0]       state,
   output logic [7:0]       slip_cnt
);

   localparam int GC_W = $clog2(LOCK_CNT + 1);
   localparam int BC_W = $clog2(UNLOCK_CNT + 1);
   localparam logic [CNT_W-1:0] PCNT_MAX = '1;
   localparam logic [CNT_W:0]   ONE_E    = (CNT_W+1)'(1);

   logic             ref_rise_s, fb_rise_s;
   logic             sat_s, close_s, good_s;
   logic [CNT_W:0]   per_s, fpos_e_s, err_s, mag_s;
   logic [CNT_W-1:0] pcnt_r, fpos_r, phase_err_r;
   logic [1:0]       fb_n_r;
   logic             phase_valid_r, lock_r, lock_lost_r, skip_r;
   logic [GC_W-1:0]  good_cnt_r;
   logic [BC_W-1:0]  bad_cnt_r;
   ld_state_e        state_r;

   adpll_edge_sync u_ref_sync (.clk(clk), .rst_n(rst_n), .din(clk_ref), .rise(ref_rise_s));
   adpll_edge_sync u_fb_sync  (.clk(clk), .rst_n(rst_n), .din(fb_clk),  .rise(fb_rise_s));

   // Period close detection and signed phase error of the closing period
   always_comb begin
      sat_s    = (pcnt_r == PCNT_MAX) && !ref_rise_s;
      close_s  = ref_rise_s || sat_s;
      per_s    = {1'b0, pcnt_r} + ONE_E;
      fpos_e_s = {1'b0, fpos_r};
      if (fpos_e_s <= (per_s >> 1)) begin
         err_s = fpos_e_s;
      end else begin
         err_s = fpos_e_s - per_s;
      end
      if (err_s[CNT_W]) begin
         mag_s = ~err_s + ONE_E;
      end else begin
         mag_s = err_s;
      end
      good_s = ref_rise_s && (fb_n_r == 2'd1) && (mag_s <= {1'b0, tol});
   end

   // Period counter, feedback position and phase error outputs
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         pcnt_r        <= '0;
         fpos_r        <= '0;
         fb_n_r        <= 2'd0;
         phase_err_r   <= '0;
         phase_valid_r <= 1'b0;
      end else begin
         phase_valid_r <= 1'b0;
         if (close_s) begin
            // A feedback edge coincident with the close opens the new period at position 0.
            pcnt_r <= '0;
            fpos_r <= '0;
            fb_n_r <= fb_rise_s ? 2'd1 : 2'd0;
            if (ref_rise_s && (fb_n_r == 2'd1)) begin
               phase_err_r   <= err_s[CNT_W-1:0];
               phase_valid_r <= 1'b1;
            end
         end else begin
            pcnt_r <= pcnt_r + CNT_W'(1);
            if (fb_rise_s) begin
               fpos_r <= pcnt_r + CNT_W'(1);
               fb_n_r <= fbn_inc(fb_n_r);
            end
         end
      end
   end

   // Lock qualification FSM, scored once per period close
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         state_r     <= ST_IDLE;
         lock_r      <= 1'b0;
         lock_lost_r <= 1'b0;
         good_cnt_r  <= '0;
         bad_cnt_r   <= '0;
         skip_r      <= 1'b0;
      end else begin
         lock_lost_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               state_r    <= ST_ACQ;
               good_cnt_r <= '0;
               bad_cnt_r  <= '0;
               skip_r     <= 1'b1;
            end
            ST_ACQ: begin
               if (close_s) begin
                  if (skip_r) begin
                     skip_r <= 1'b0;
                  end else if (good_s) begin
                     if (good_cnt_r == GC_W'(LOCK_CNT - 1)) begin
                        state_r    <= ST_LOCKED;
                        lock_r     <= 1'b1;
                        good_cnt_r <= '0;
                     end else begin
                        good_cnt_r <= good_cnt_r + GC_W'(1);
                     end
                  end else begin
                     good_cnt_r <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (close_s && !good_s) begin
                  if (UNLOCK_CNT == 1) begin
                     state_r     <= ST_ACQ;
                     lock_r      <= 1'b0;
                     lock_lost_r <= 1'b1;
                     good_cnt_r  <= '0;
                     skip_r      <= 1'b1;
                  end else begin
                     state_r   <= ST_HOLD;
                     bad_cnt_r <= BC_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (close_s) begin
                  if (good_s) begin
                     state_r   <= ST_LOCKED;
                     bad_cnt_r <= '0;
                  end else if (bad_cnt_r == BC_W'(UNLOCK_CNT - 1)) begin
                     state_r     <= ST_ACQ;
                     lock_r      <= 1'b0;
                     lock_lost_r <= 1'b1;
                     good_cnt_r  <= '0;
                     bad_cnt_r   <= '0;
                     skip_r      <= 1'b1;
                  end else begin
                     bad_cnt_r <= bad_cnt_r + BC_W'(1);
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               lock_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADPLL_LD_SLIP_CNT_EN
   logic [7:0] slip_r;

   // Count closed periods that did not see exactly one feedback edge
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         slip_r <= 8'd0;
      end else if (close_s && (fb_n_r != 2'd1) && (slip_r != 8'hFF)) begin
         slip_r <= slip_r + 8'd1;
      end
   end

   assign slip_cnt = slip_r;
`else
   assign slip_cnt = 8'd0;
`endif

   assign lock        = lock_r;
   assign lock_lost   = lock_lost_r;
   assign phase_err   = phase_err_r;
   assign phase_valid = phase_valid_r;
   assign state       = state_r;

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Self-checking bench for adpll_lock_detect: pin-level phase model feeds a scoreboard queue,
// FSM/lock milestones are checked at fixed points of a 40-cycle reference pattern.
module tb_adpll_lock_detect;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       clk_ref = 1'b0;
   logic       fb_clk = 1'b0;
   logic [7:0] tol = 8'd2;
   logic       lock, lock_lost, phase_valid;
   logic [7:0] phase_err, slip_cnt;
   logic [1:0] state;

   int checks = 0;
   int failures = 0;
   int ph = 0;
   bit ref_on = 1'b1;
   bit fb_on = 1'b1;
   int fb_off = 1;
   bit ref_prev = 1'b0;
   bit fb_prev = 1'b0;
   int m_cnt = 0;
   int m_fbn = 0;
   int m_fpos = 0;
   bit m_armed = 1'b0;
   int exp_q[$];
   int exp_v;
   int ll_cnt = 0;
   int slip0;
   int slip_delta_exp;

   adpll_lock_detect #(.CNT_W(8), .LOCK_CNT(16), .UNLOCK_CNT(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clk_ref(clk_ref), .fb_clk(fb_clk), .tol(tol),
      .lock(lock), .lock_lost(lock_lost), .phase_err(phase_err), .phase_valid(phase_valid),
      .state(state), .slip_cnt(slip_cnt)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (ph=%0d)", tag, obs, exp, ph);
      end
   endtask

   function automatic int exp_err(input int f, input int c);
      int p;
      p = c + 1;
      if (f <= p / 2) return f;
      return f - p;
   endfunction

   // One clk cycle of pin stimulus plus the pin-level phase model
   task automatic step();
      bit ref_v, fb_v, ref_rise, fb_rise;
      @(negedge clk);
      ref_v = ref_on && ((ph % 40) < 20);
      fb_v  = fb_on && (((ph - fb_off + 40) % 40) == 0);
      clk_ref = ref_v;
      fb_clk  = fb_v;
      ref_rise = ref_v && !ref_prev;
      fb_rise  = fb_v && !fb_prev;
      ref_prev = ref_v;
      fb_prev  = fb_v;
      if (!en || !rst_n) m_armed = 1'b0;
      if (ref_rise) begin
         if (m_armed && m_fbn == 1) exp_q.push_back(exp_err(m_fpos, m_cnt));
         m_armed = en && rst_n;
         m_cnt = 0;
         m_fbn = fb_rise ? 1 : 0;
         m_fpos = 0;
      end else begin
         if (m_cnt < 255) m_cnt++;
         if (fb_rise) begin
            if (m_fbn < 2) m_fbn++;
            m_fpos = m_cnt;
         end
      end
      ph++;
   endtask

   task automatic run_to(input int t);
      while (ph < t) step();
   endtask

   task automatic check_st(input string tag, input int st, input int lk);
      check_eq({tag, "_state"}, int'(state), st);
      check_eq({tag, "_lock"}, int'(lock), lk);
   endtask

   // Scoreboard consumer and lock_lost pulse counter
   always @(negedge clk) begin
      if (lock_lost === 1'b1) ll_cnt++;
      if (phase_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("phase_unexp", int'(phase_valid), 0);
         end else begin
            exp_v = exp_q.pop_front();
            check_eq("phase_err", int'($signed(phase_err)), exp_v);
         end
      end
   end

   initial begin
`ifdef ADPLL_LD_SLIP_CNT_EN
      slip_delta_exp = 4;
`else
      slip_delta_exp = 0;
`endif
      run_to(4);
      check_st("reset", 0, 0);
      check_eq("reset_lock_lost", int'(lock_lost), 0);
      check_eq("reset_phase_err", int'(phase_err), 0);
      check_eq("reset_phase_valid", int'(phase_valid), 0);
      check_eq("reset_slip", int'(slip_cnt), 0);
      rst_n = 1'b1;
      run_to(59);
      check_st("idle_en0", 0, 0);
      en = 1'b1;
      run_to(62);
      check_st("acq_entry", 1, 0);

      // lag 1: 16 good closes at 120..720
      run_to(710);  check_st("acq_15good", 1, 0);
      run_to(730);  check_st("locked_16good", 2, 1);

      // boundary goods +2 / -2, then 2 bad and 1 good
      run_to(739);  fb_off = 2;
      run_to(799);  fb_off = 38;
      run_to(879);  fb_off = 37;
      run_to(930);  check_st("hold_bad1", 3, 1);
      run_to(959);  fb_off = 38;
      run_to(970);  check_st("hold_bad2", 3, 1);
      run_to(1010); check_st("relocked", 2, 1);
      check_eq("no_lock_lost_hold", ll_cnt, 0);

      // lead 3 for 4 periods: unlock
      run_to(1039); fb_off = 37;
      run_to(1090); check_st("lead_hold", 3, 1);
      run_to(1190); check_st("lead_hold3", 3, 1);
      check_eq("lock_lost_before", ll_cnt, 0);
      run_to(1199); fb_off = 1;
      run_to(1210); check_st("unlock", 1, 0);
      check_eq("lock_lost_pulse", ll_cnt, 1);

      // first period after ACQ entry is discarded: lock on close 1880, not 1840
      run_to(1850); check_st("discard_acq", 1, 0);
      run_to(1890); check_st("relock2", 2, 1);

      // feedback stopped
      run_to(1900); fb_on = 1'b0;
      run_to(1930); slip0 = int'(slip_cnt);
      run_to(1970); check_st("fbstop_hold", 3, 1);
      run_to(2090); check_st("fbstop_unlock", 1, 0);
      check_eq("fbstop_lock_lost", ll_cnt, 2);
      check_eq("fbstop_phase_hold", int'($signed(phase_err)), 1);
      check_eq("slip_delta", int'(slip_cnt) - slip0, slip_delta_exp);

      // relock, then reference stopped: saturation closes every 256 cycles
      run_to(2119); fb_on = 1'b1; fb_off = 1;
      run_to(2750); check_st("relock3_pre", 1, 0);
      run_to(2770); check_st("relock3", 2, 1);
      run_to(2780); ref_on = 1'b0;
      run_to(3000); check_st("refstop_locked", 2, 1);
      run_to(3100); check_st("refstop_hold", 3, 1);
      run_to(3700); check_st("refstop_hold3", 3, 1);
      run_to(3850); check_st("refstop_unlock", 1, 0);
      check_eq("refstop_lock_lost", ll_cnt, 3);

      // relock, then en=0 mid-LOCKED
      run_to(3880); ref_on = 1'b1;
      run_to(4510); check_st("relock4_pre", 1, 0);
      run_to(4530); check_st("relock4", 2, 1);
      run_to(4540); en = 1'b0;
      run_to(4542);
      check_st("en0", 0, 0);
      check_eq("en0_lock_lost", int'(lock_lost), 0);
      check_eq("en0_phase_err", int'(phase_err), 0);
      check_eq("en0_phase_valid", int'(phase_valid), 0);
      check_eq("en0_slip", int'(slip_cnt), 0);
      check_eq("en0_no_pulse", ll_cnt, 3);

      // re-enable, coincident edges (err 0), then reset mid-LOCKED
      run_to(4580); en = 1'b1;
      run_to(4759); fb_off = 0;
      run_to(5250); check_st("relock5", 2, 1);
      run_to(5260); rst_n = 1'b0;
      run_to(5262);
      check_st("rst_mid", 0, 0);
      check_eq("rst_phase_err", int'(phase_err), 0);
      check_eq("rst_slip", int'(slip_cnt), 0);
      rst_n = 1'b1;
      run_to(5270); check_st("rst_release", 1, 0);
      run_to(5400);
      check_eq("rst_no_pulse", ll_cnt, 3);
      check_eq("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
